// File: rtl/opsel_pkg.sv
// opsel_pkg: shared constants, skid state encoding and select-width helper for operand_select_stage
package opsel_pkg;
  localparam int OPSEL_MAX_NSRC = 16;
  typedef enum logic [1:0] {
    OPSEL_EMPTY = 2'b00,
    OPSEL_ONE   = 2'b01,
    OPSEL_FULL  = 2'b11
  } opsel_state_e;
  function automatic int opsel_selw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/opsel_skid.sv
// opsel_skid: two-entry skid buffer; state is {skid_v, main_v}, main drives the outputs
module opsel_skid
  import opsel_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  opsel_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OPSEL_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
  always_comb begin
    acc     = in_valid && in_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      OPSEL_EMPTY: if (acc) begin
        state_d = OPSEL_ONE;
        main_d  = in_data;
      end
      OPSEL_ONE: if (acc && out_ready) main_d = in_data;
        else if (acc) begin
          skid_d  = in_data;
          state_d = OPSEL_FULL;
        end else if (out_ready) state_d = OPSEL_EMPTY;
      OPSEL_FULL: if (out_ready) begin
        main_d  = skid_q;
        state_d = OPSEL_ONE;
      end
      default: state_d = OPSEL_EMPTY;
    endcase
  end
  // in_ready depends only on registered state and rst, never on out_ready
  always_comb begin
    in_ready  = (state_q != OPSEL_FULL) && !rst;
    out_valid = state_q[0] && !rst;
    out_data  = main_q;
  end
endmodule

// File: rtl/operand_select_stage.sv
// operand_select_stage: registered N-way operand selector with skid output; OPSEL_ERR_EN adds sticky sel_err
module operand_select_stage
  import opsel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  localparam int SELW = opsel_selw(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel
`ifdef OPSEL_ERR_EN
  ,output logic                 sel_err
`endif
);
  logic [WIDTH-1:0] sel_data;
  logic [SELW+WIDTH-1:0] pkt;
  // out-of-range selects match no source and fall through to zero
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++) if (sel == SELW'(k)) sel_data = src[k*WIDTH +: WIDTH];
  end
  opsel_skid #(.W(SELW + WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel, sel_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pkt)
  );
  assign {out_sel, out_data} = pkt;
`ifdef OPSEL_ERR_EN
  logic sel_err_q;
  always_ff @(posedge clk)
    sel_err_q <= rst ? 1'b0 : sel_err_q | (in_valid && in_ready && {1'b0, sel} >= (SELW+1)'(NSRC));
  assign sel_err = sel_err_q;
`endif
endmodule

// File: tb/tb_operand_select_stage.sv
// tb_operand_select_stage: randomized + directed check of NSRC=4 and NSRC=3 instances against a depth-2 FIFO model
module tb_operand_select_stage;
  localparam int W = 32;
  typedef struct {
    logic [1:0]   s;
    logic [W-1:0] d4;
    logic [W-1:0] d3;
  } ent_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [1:0] sel = 0;
  logic [4*W-1:0] src = '0;
  logic rdy4, rdy3, ov4, ov3;
  logic [W-1:0] d4, d3;
  logic [1:0] s4, s3;
`ifdef OPSEL_ERR_EN
  logic err4, err3;
`endif
  ent_t q[$];
  bit err_m;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  operand_select_stage #(.WIDTH(W), .NSRC(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .sel(sel), .src(src),
    .out_valid(ov4), .out_ready(out_ready), .out_data(d4), .out_sel(s4)
`ifdef OPSEL_ERR_EN
    , .sel_err(err4)
`endif
  );
  operand_select_stage #(.WIDTH(W), .NSRC(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .sel(sel), .src(src[3*W-1:0]),
    .out_valid(ov3), .out_ready(out_ready), .out_data(d3), .out_sel(s3)
`ifdef OPSEL_ERR_EN
    , .sel_err(err3)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // model: bounded FIFO of depth 2; accept when fewer than 2 held, drain head when out_ready
  task automatic tick();
    int n;
    ent_t e;
    @(posedge clk);
    n = q.size();
    if (rst) begin
      q.delete();
      err_m = 0;
    end else begin
      if (in_valid && n < 2) begin
        e.s  = sel;
        e.d4 = src[int'(sel)*W +: W];
        e.d3 = (sel < 3) ? e.d4 : '0;
        if (sel >= 3) err_m = 1;
      end
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back(e);
    end
    #1;
    chk("in_ready4", rdy4, !rst && q.size() < 2);
    chk("in_ready3", rdy3, !rst && q.size() < 2);
    chk("out_valid4", ov4, !rst && q.size() > 0);
    chk("out_valid3", ov3, !rst && q.size() > 0);
    if (!rst && q.size() > 0) begin
      chk("out_data4", d4, q[0].d4);
      chk("out_sel4", s4, q[0].s);
      chk("out_data3", d3, q[0].d3);
      chk("out_sel3", s3, q[0].s);
    end
`ifdef OPSEL_ERR_EN
    chk("sel_err4", err4, 0);
    chk("sel_err3", err3, err_m);
`endif
  endtask
  task automatic cyc(input bit v, input bit [1:0] s, input bit r);
    in_valid = v;
    sel = s;
    out_ready = r;
    tick();
  endtask
  initial begin
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_data", d4, 0);
      chk("rst_sel", s4, 0);
    end
    rst = 0;
    in_valid = 0;
    #1 chk("ready_after_rst", rdy4, 1);
    src = {32'h4, 32'h3, 32'h2, 32'h1};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 2'(i), 1);
      chk("stream", d4, i + 1);
    end
    cyc(0, 0, 1);
    cyc(1, 1, 0);
    cyc(1, 2, 0);
    chk("bp_full", rdy4, 0);
    cyc(0, 0, 1);
    chk("bp_first", d4, 3);
    chk("bp_ready", rdy4, 1);
    cyc(0, 0, 1);
    src[2*W +: W] = 32'hDEADBEEF;
    cyc(1, 2, 0);
    src[2*W +: W] = '0;
    cyc(0, 0, 0);
    chk("capture", d4, 32'hDEADBEEF);
    cyc(0, 0, 1);
    cyc(1, 3, 1);
    chk("oor_data", d3, 0);
    chk("oor_sel", s3, 3);
    cyc(0, 0, 1);
    src = {32'h44, 32'h33, 32'h22, 32'h11};
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    rst = 1;
    cyc(0, 0, 0);
    chk("rst_full", ov4, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      src = {$urandom(), $urandom(), $urandom(), $urandom()};
      rst = ($urandom_range(0, 99) == 0);
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_select_stage.md
# operand_select_stage

Parametrised, registered N-way operand selector for the CPU datapath; the pipelined successor of the 2:1 combinational operand muxes. It picks one of NSRC WIDTH-bit sources per transaction and presents the result through a valid/ready output with a two-entry skid buffer. Sustained throughput is one operand per cycle. It sits between the register-read/forwarding sources and the ALU operand register, decoupling selection from downstream stalls.

## Interface
- WIDTH, 32: operand width in bits.
- NSRC, 4: number of sources; 2 to 16; need not be a power of two.
- SELW, $clog2(NSRC) (minimum 1): select width; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a select request is present.
- in_ready  out  1  the block accepts a request this cycle.
- sel  in  SELW  source index for this request.
- src  in  NSRC*WIDTH  flattened sources; source k is src[k*WIDTH +: WIDTH].
- out_valid  out  1  out_data/out_sel hold a valid result.
- out_ready  in  1  the consumer takes the result this cycle.
- out_data  out  WIDTH  selected operand.
- out_sel  out  SELW  index that produced out_data.
- sel_err  out  1  sticky out-of-range flag (present only with OPSEL_ERR_EN).

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- On accept, the block captures src[sel] and sel together in that cycle. Later changes to src do not affect a captured entry.
- If sel >= NSRC, the captured data is all zeros and the transaction still completes.
- Storage has two entries:
  - main (drives outputs)
  - skid
- State machine, encoded by the pair {skid_v, main_v}:
  - EMPTY (0,0): accept loads main, go to ONE.
  - ONE (0,1):
    - accept with out_ready: main reloads, stay in ONE.
    - accept without out_ready: load skid, go to FULL.
    - no accept with out_ready: go to EMPTY.
  - FULL (1,1): in_ready=0. When out_ready is high, skid moves to main and the state goes to ONE.
- in_ready = !skid_v && !rst. It is a function of registers only, with no combinational path from out_ready.
- out_valid = main_v. out_data and out_sel come from main.
- Ordering is strict FIFO; no request is dropped or duplicated.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle while out_ready is held high.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, in_ready=0 during rst.
  - in_ready=1 in the first cycle after rst deasserts.
  - sel_err=0.
- Reset mid-operation: both entries are discarded and no output handshake completes. Any accept asserted in the rst cycle is ignored.
- Simultaneous accept and drain in ONE: the new value replaces main and the skid stays empty.
- Simultaneous events in FULL: there is no accept, because in_ready=0.
- out_data/out_sel stay stable while out_valid && !out_ready.

## Configuration
- OPSEL_ERR_EN defined:
  - sel_err port exists.
  - It sets at the clock edge of any accepted request with sel >= NSRC and holds until rst.
  - Data behaviour is unchanged (zeros).
- OPSEL_ERR_EN undefined: there is no sel_err port and no detection logic. Out-of-range selects silently yield zeros.
- When NSRC is a power of two, the error can never fire; sel_err stays 0.

## Structure
- Shared package/header opsel_pkg:
  - OPSEL_MAX_NSRC=16
  - state encodings OPSEL_EMPTY/ONE/FULL
  - the SELW derivation function
- One sub-module, opsel_skid: a WIDTH+SELW two-entry skid buffer holding the state machine.
- The top level holds the source select/zeroing logic and the error flag.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, in_ready=0 throughout. in_ready=1 on the first cycle after release.
- Streaming: NSRC=4, src={0x4,0x3,0x2,0x1} (source k = k+1), sel=0,1,2,3 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 on cycles +1..+4, out_sel matching, no bubbles.
- Backpressure: out_ready=0, send sel=1 then sel=2 -> in_ready drops after the second accept. Raise out_ready -> outputs 0x2 then 0x3, in order. in_ready returns 1 a cycle after the first drain.
- Data capture: accept sel=2 with src[2]=0xDEADBEEF, change src[2] to 0 the next cycle while stalled -> out_data stays 0xDEADBEEF.
- Out of range (NSRC=3, OPSEL_ERR_EN): sel=3 -> out_data=0, out_sel=3, sel_err=1 from the next cycle until rst. Rebuilt without the macro -> same data result and no port.
- Reset while FULL: assert rst with both entries occupied -> out_valid=0 next cycle and neither stored value ever appears.
